twiddle_gen: RTL and testbench

//  Sequencer that fills the FFT twiddle-factor RAM before each FFT pass. For k = 0..NFFT/2-1 it:
//  - computes the angle beta_k = -2*pi*k/NFFT;
//  - runs one cossin_cordic transaction per k;
//  - writes cos/sin into RAM at address k.

---
 rtl/twiddle_gen.sv | 196 +++++++++++++++++++
 tb/tb_twiddle_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_gen
// Description : Fills the FFT twiddle-factor RAM. For k = 0..NFFT/2-1 it forms
//               the angle beta_k = -2*pi*k/NFFT (sign-magnitude), runs one
//               cossin_cordic transaction and writes cos/sin to address k.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock
//   rst          in   asynchronous reset, active-low
//   start        in   one-cycle request to (re)generate the table (IDLE only)
//   busy         out  high while a table generation is in progress
//   done         out  one-cycle pulse at completion or timeout abort
//   err          out  sticky cordic timeout flag, cleared on accepted start
//   startcossin  out  one-cycle start pulse to cossin_cordic
//   beta         out  angle to cossin_cordic, stable from pulse to WRITE
//   cos_in       in   cos result from cossin_cordic
//   sin_in       in   sin result from cossin_cordic
//   donecossin   in   cossin_cordic done level (low while busy)
//   tw_we        out  twiddle RAM write enable pulse
//   tw_addr      out  twiddle RAM write address (k)
//   tw_cos       out  twiddle RAM write data, cos
//   tw_sin       out  twiddle RAM write data, sin
// ============================================================================
module twiddle_gen #(
   parameter int N         = 32,
   parameter int Q         = 16,
   parameter int NFFT      = 512,
   parameter int LOG2_NFFT = 9,
   parameter int STEP      = 804,
   parameter int TMO       = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   startcossin,
   output logic [N-1:0]           beta,
   input  logic [N-1:0]           cos_in,
   input  logic [N-1:0]           sin_in,
   input  logic                   donecossin,
   output logic                   tw_we,
   output logic [LOG2_NFFT-2:0]   tw_addr,
   output logic [N-1:0]           tw_cos,
   output logic [N-1:0]           tw_sin
);

   localparam int c_KW = LOG2_NFFT - 1;
   localparam int c_TW = (TMO < 1) ? 1 : $clog2(TMO + 1);

   localparam logic [c_KW-1:0] c_KLAST = c_KW'(NFFT / 2 - 1);
   localparam logic [c_TW-1:0] c_TMO   = c_TW'(TMO);
   localparam logic [N-2:0]    c_STEP  = (N - 1)'(STEP);

   // Parameter sanity: the table needs at least two entries, NFFT must match
   // LOG2_NFFT, and the fraction must leave room for sign and integer bits.
   if (NFFT < 4 || (1 << LOG2_NFFT) != NFFT || Q >= N - 1) begin : g_param_check
      $error("twiddle_gen: inconsistent NFFT/LOG2_NFFT/Q parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SET    = 3'd1,
      S_PULSE  = 3'd2,
      S_WLOW   = 3'd3,
      S_WHIGH  = 3'd4,
      S_WRITE  = 3'd5,
      S_NEXT   = 3'd6,
      S_FINISH = 3'd7
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_KW-1:0]   r_k, w_k_nxt;
   logic [N-2:0]      r_mag, w_mag_nxt;       // k*STEP, accumulated
   logic [c_TW-1:0]   r_tmr, w_tmr_nxt;       // per-edge timeout counter
   logic              r_err, w_err_nxt;
   logic [N-1:0]      r_beta, w_beta_nxt;
   logic [N-1:0]      r_tw_cos, w_tw_cos_nxt;
   logic [N-1:0]      r_tw_sin, w_tw_sin_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_mag    <= '0;
         r_tmr    <= '0;
         r_err    <= 1'b0;
         r_beta   <= '0;
         r_tw_cos <= '0;
         r_tw_sin <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_k      <= w_k_nxt;
         r_mag    <= w_mag_nxt;
         r_tmr    <= w_tmr_nxt;
         r_err    <= w_err_nxt;
         r_beta   <= w_beta_nxt;
         r_tw_cos <= w_tw_cos_nxt;
         r_tw_sin <= w_tw_sin_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_k_nxt      = r_k;
      w_mag_nxt    = r_mag;
      w_tmr_nxt    = r_tmr;
      w_err_nxt    = r_err;
      w_beta_nxt   = r_beta;
      w_tw_cos_nxt = r_tw_cos;
      w_tw_sin_nxt = r_tw_sin;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_k_nxt     = '0;
               w_mag_nxt   = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_SET;
            end
         end
         S_SET: begin
            // Angle zero is encoded as +0; there is no negative zero.
            w_beta_nxt  = (r_k == '0) ? '0 : {1'b1, r_mag};
            w_state_nxt = S_PULSE;
         end
         S_PULSE: begin
            w_tmr_nxt   = '0;
            w_state_nxt = S_WLOW;
         end
         S_WLOW: begin
            // The falling edge must be seen before results are trusted, so
            // a still-high level from the previous transaction is not taken.
            if (!donecossin) begin
               w_tmr_nxt   = '0;
               w_state_nxt = S_WHIGH;
            end else if (r_tmr == c_TMO) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_FINISH;
            end else begin
               w_tmr_nxt   = r_tmr + 1'b1;
            end
         end
         S_WHIGH: begin
            if (donecossin) begin
               w_tw_cos_nxt = cos_in;
               w_tw_sin_nxt = sin_in;
               w_state_nxt  = S_WRITE;
            end else if (r_tmr == c_TMO) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_FINISH;
            end else begin
               w_tmr_nxt   = r_tmr + 1'b1;
            end
         end
         S_WRITE: begin
            w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (r_k == c_KLAST) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_k_nxt     = r_k + 1'b1;
               w_mag_nxt   = r_mag + c_STEP;
               w_state_nxt = S_SET;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Pulse outputs decode straight from the state register so that an
   // asynchronous reset clears them in the same cycle.
   always_comb begin
      busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
      done        = (r_state == S_FINISH);
      startcossin = (r_state == S_PULSE);
      tw_we       = (r_state == S_WRITE);
   end

   assign err     = r_err;
   assign beta    = r_beta;
   assign tw_addr = r_k;
   assign tw_cos  = r_tw_cos;
   assign tw_sin  = r_tw_sin;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_gen
// Description : Scoreboard bench for twiddle_gen with a behavioural 3-cycle
//               cordic model. Expected angles, writes and done/err outcomes are
//               queued when a run is launched; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_gen;

   localparam int N    = 32;
   localparam int NFFT = 512;
   localparam int HALF = NFFT / 2;
   localparam int TMO  = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, err, startcossin, tw_we;
   logic [N-1:0]  beta, cos_in, sin_in, tw_cos, tw_sin;
   logic          donecossin;
   logic [7:0]    tw_addr;
   logic          stuck = 1'b0;

   always #5 clk = ~clk;

   twiddle_gen #(.N(N), .Q(16), .NFFT(NFFT), .LOG2_NFFT(9), .STEP(804), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .startcossin(startcossin), .beta(beta), .cos_in(cos_in), .sin_in(sin_in),
      .donecossin(donecossin), .tw_we(tw_we), .tw_addr(tw_addr),
      .tw_cos(tw_cos), .tw_sin(tw_sin)
   );

   // ---------------- behavioural cordic: low 2..4 cycles after the pulse
   function automatic logic [31:0] fcos(input logic [31:0] b);
      return b ^ 32'h5A5AC3C3;
   endfunction
   function automatic logic [31:0] fsin(input logic [31:0] b);
      return {b[15:0], b[31:16]} ^ 32'h0F0F0F0F;
   endfunction

   logic [2:0]  m_cnt;
   logic [31:0] m_lat;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt <= 3'd0; m_lat <= '0; cos_in <= '0; sin_in <= '0;
      end else if (startcossin) begin
         m_cnt <= 3'd1; m_lat <= beta;
      end else if (m_cnt == 3'd4) begin
         m_cnt <= 3'd0; cos_in <= fcos(m_lat); sin_in <= fsin(m_lat);
      end else if (m_cnt != 3'd0) begin
         m_cnt <= m_cnt + 3'd1;
      end
   end
   assign donecossin = stuck ? 1'b1 : (m_cnt < 3'd2);

   // ---------------- scoreboard
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] c;
      logic [31:0] s;
   } wr_t;

   wr_t         q_wr[$];
   logic [31:0] q_beta[$];
   logic        q_err[$];
   int          checks = 0;
   int          errors = 0;
   int          n_wr = 0;
   wr_t         m_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event expected=none", name);
   endtask

   // Hand-computed anchors, STEP accumulation for the rest.
   function automatic logic [31:0] exp_beta(input int k);
      logic [31:0] p;
      case (k)
         0:       return 32'h00000000;
         1:       return 32'h80000324;
         128:     return 32'h80019200;
         255:     return 32'h800320DC;
         default: begin
            p = k * 804;
            return {1'b1, p[30:0]};
         end
      endcase
   endfunction

   task automatic push_run();
      wr_t e;
      for (int k = 0; k < HALF; k++) begin
         q_beta.push_back(exp_beta(k));
         e.addr = 8'(k);
         e.c    = fcos(exp_beta(k));
         e.s    = fsin(exp_beta(k));
         q_wr.push_back(e);
      end
      q_err.push_back(1'b0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (startcossin) begin
            if (q_beta.size() == 0) unexpected("startcossin");
            else chk("beta", beta, q_beta.pop_front());
         end
         if (tw_we) begin
            n_wr++;
            if (q_wr.size() == 0) unexpected("tw_we");
            else begin
               m_e = q_wr.pop_front();
               chk("tw_addr", {24'h0, tw_addr}, {24'h0, m_e.addr});
               chk("tw_cos", tw_cos, m_e.c);
               chk("tw_sin", tw_sin, m_e.s);
            end
         end
         if (done) begin
            if (q_err.size() == 0) unexpected("done");
            else chk("err_at_done", {31'h0, err}, {31'h0, q_err.pop_front()});
         end
      end
   end

   // ---------------- stimulus helpers (act half a cycle plus 1 after negedge)
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) unexpected("done_timeout");
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_err"}, {31'h0, err}, 32'h0);
      chk({tag, "_startcossin"}, {31'h0, startcossin}, 32'h0);
      chk({tag, "_tw_we"}, {31'h0, tw_we}, 32'h0);
      chk({tag, "_beta"}, beta, 32'h0);
      chk({tag, "_tw_addr"}, {24'h0, tw_addr}, 32'h0);
      chk({tag, "_tw_cos"}, tw_cos, 32'h0);
      chk({tag, "_tw_sin"}, tw_sin, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      bit ok;

      // Reset state
      #12;
      chk_all_zero("reset");
      tick(); rst = 1'b1;

      // Full run: 256 writes, addresses in order, err=0
      n_wr = 0;
      push_run();
      pulse_start();
      chk("busy_after_start", {31'h0, busy}, 32'h1);
      wait_done(4000);
      chk("busy_in_finish", {31'h0, busy}, 32'h0);
      chk("run1_writes", n_wr, HALF);
      tick();
      chk("done_one_cycle", {31'h0, done}, 32'h0);
      chk("run1_queue_empty", q_wr.size(), 0);

      // Cordic never drops its done level: timeout after TMO+1 WAIT_LOW cycles
      stuck = 1'b1;
      n_wr  = 0;
      q_beta.push_back(exp_beta(0));
      q_err.push_back(1'b1);
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (startcossin) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) unexpected("stuck_no_pulse");
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         tick(); cyc++;
         if (done) break;
      end
      chk("timeout_latency", cyc, TMO + 2);
      chk("timeout_err", {31'h0, err}, 32'h1);
      chk("timeout_no_write", n_wr, 0);
      tick();
      chk("timeout_busy_after", {31'h0, busy}, 32'h0);
      chk("err_sticky", {31'h0, err}, 32'h1);
      stuck = 1'b0;

      // New start clears err; a second start mid-run is ignored
      n_wr = 0;
      push_run();
      pulse_start();
      chk("err_cleared", {31'h0, err}, 32'h0);
      for (int i = 0; i < 4000 && n_wr < 50; i++) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done(4000);
      chk("run_midstart_writes", n_wr, HALF);

      // Start during FINISH is ignored; held into IDLE it launches a new run
      n_wr = 0;
      push_run();
      start = 1'b1;
      tick();
      chk("finish_start_ignored", {31'h0, busy}, 32'h0);
      tick(); start = 1'b0;
      chk("idle_start_taken", {31'h0, busy}, 32'h1);

      // Reset at k=100 while waiting for the cordic to finish
      for (int i = 0; i < 4000 && n_wr < 100; i++) tick();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (startcossin) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) unexpected("k100_no_pulse");
      for (int i = 0; i < 20 && donecossin; i++) tick();
      tick();
      chk("pre_reset_addr", {24'h0, tw_addr}, 32'd100);
      chk("pre_reset_beta", beta, 32'h80013A10);
      chk("pre_reset_writes", n_wr, 100);
      rst = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      q_wr.delete();
      q_beta.delete();
      q_err.delete();
      tick(); rst = 1'b1;

      // Restart from k=0 after reset
      n_wr = 0;
      push_run();
      pulse_start();
      wait_done(4000);
      chk("restart_writes", n_wr, HALF);
      chk("restart_err", {31'h0, err}, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
